// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
package regfile_pkg;

    typedef enum logic {
        INIT,
        RUN
    } rf_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset sweep sequencer: zeroes every entry once, then raises ready.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              ready
);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we   = 1'b0;
        init_addr = cnt_q;
        ready     = 1'b0;
        unique case (state_q)
            INIT: begin
                init_we = 1'b1;
                if (&cnt_q) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: state_d = INIT;
        endcase
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read, one-write register file with per-entry pending-write flags.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              stall
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              fn_we;
    logic              rsv_ok;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    regfile_init_seq #(
        .ADDR_W(ADDR_W)
    ) u_init (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_we  (init_we),
        .init_addr(init_addr),
        .ready    (ready)
    );

    assign fn_we    = ready && we && writable(wa);
    assign mem_we   = init_we || fn_we;
    assign mem_addr = init_we ? init_addr : wa;
    assign mem_data = init_we ? '0 : wd;

    // Storage is never reset; the init sweep clears it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (!ready || !writable(a)) begin
            v = '0;
        end else if (we && wa == a) begin
            v = wd;
        end else begin
            v = mem[a];
        end
        return v;
    endfunction

    assign rd1 = rd_port(ra1);
    assign rd2 = rd_port(ra2);

    assign busy1 = ready && busy_q[ra1] && !(we && wa == ra1);
    assign busy2 = ready && busy_q[ra2] && !(we && wa == ra2);

    assign stall = rsv_en && (!ready ||
                   (busy_q[rsv_addr] && !(we && wa == rsv_addr)));
    assign rsv_ok = rsv_en && !stall && writable(rsv_addr);

    // Reserve is applied after release so it wins on a same-address clash.
    always_comb begin
        busy_d = busy_q;
        if (fn_we) begin
            busy_d[wa] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default 32x32 geometry.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic [4:0]  ra1, ra2, wa, rsv_addr;
    logic [31:0] rd1, rd2, wd;
    logic        busy1, busy2, we, rsv_en, stall;

    int total;
    int bad;

    regfile_scoreboard dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ready   (ready),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .busy1   (busy1),
        .busy2   (busy2),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        ra1      = '0;
        ra2      = '0;
        wa       = '0;
        wd       = '0;
        we       = 1'b0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        #3;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        #9;
        rst_n = 1'b1;

        // Sweep: reserve requests must be refused while not ready
        rsv_en   = 1'b1;
        rsv_addr = 5'd4;
        ra1      = 5'd4;
        for (int i = 0; i < 32; i++) begin
            #1;
            check($sformatf("init_ready_%0d", i), 32'(ready), 32'd0);
            check($sformatf("init_stall_%0d", i), 32'(stall), 32'd1);
            check($sformatf("init_rd1_%0d", i), rd1, 32'd0);
            step();
        end
        rsv_en = 1'b0;
        #1;
        check("ready_after_32", 32'(ready), 32'd1);
        check("rsv_ignored_busy", 32'(busy1), 32'd0);

        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            check($sformatf("zero_rd1_%0d", a), rd1, 32'd0);
            check($sformatf("zero_rd2_%0d", a), rd2, 32'd0);
            check($sformatf("idle_busy1_%0d", a), 32'(busy1), 32'd0);
        end

        // Write-through bypass
        we  = 1'b1;
        wa  = 5'd3;
        wd  = 32'hDEAD_BEEF;
        ra1 = 5'd3;
        ra2 = 5'd4;
        #1;
        check("bypass_rd1", rd1, 32'hDEAD_BEEF);
        check("bypass_rd2_other", rd2, 32'd0);
        step();
        we = 1'b0;
        #1;
        check("stored_rd1", rd1, 32'hDEAD_BEEF);

        // Reserve, double reserve, same-cycle write+reserve
        rsv_en   = 1'b1;
        rsv_addr = 5'd5;
        ra1      = 5'd5;
        ra2      = 5'd5;
        #1;
        check("rsv5_stall", 32'(stall), 32'd0);
        step();
        #1;
        check("rsv5_busy1", 32'(busy1), 32'd1);
        check("rsv5_busy2", 32'(busy2), 32'd1);
        check("rsv5_again_stall", 32'(stall), 32'd1);
        we = 1'b1;
        wa = 5'd5;
        wd = 32'h0000_0077;
        #1;
        check("wr_rsv_stall", 32'(stall), 32'd0);
        check("wr_rsv_busy1_comb", 32'(busy1), 32'd0);
        check("wr_rsv_rd1", rd1, 32'h0000_0077);
        step();
        we     = 1'b0;
        rsv_en = 1'b0;
        #1;
        check("rsv_wins_busy1", 32'(busy1), 32'd1);
        check("rsv_wins_busy2", 32'(busy2), 32'd1);
        check("rsv_wins_rd1", rd1, 32'h0000_0077);
        check("rsv_wins_rd2", rd2, 32'h0000_0077);
        we = 1'b1;
        wd = 32'h0000_0088;
        step();
        we = 1'b0;
        #1;
        check("release_busy1", 32'(busy1), 32'd0);
        check("release_rd1", rd1, 32'h0000_0088);

        // Non-busy write is silent
        we  = 1'b1;
        wa  = 5'd6;
        wd  = 32'h0000_0066;
        ra1 = 5'd6;
        step();
        we = 1'b0;
        #1;
        check("silent_busy1", 32'(busy1), 32'd0);
        check("silent_rd1", rd1, 32'h0000_0066);

        // Register zero
        we  = 1'b1;
        wa  = 5'd0;
        wd  = 32'h0000_1234;
        ra1 = 5'd0;
        #1;
        check("r0_bypass_rd1", rd1, 32'd0);
        step();
        we = 1'b0;
        #1;
        check("r0_rd1", rd1, 32'd0);
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        #1;
        check("r0_rsv_stall", 32'(stall), 32'd0);
        step();
        #1;
        check("r0_rsv_again_stall", 32'(stall), 32'd0);
        check("r0_busy1", 32'(busy1), 32'd0);
        rsv_en = 1'b0;

        // Mid-operation reset
        we  = 1'b1;
        wa  = 5'd7;
        wd  = 32'h0000_0055;
        step();
        we       = 1'b0;
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        step();
        rsv_en = 1'b0;
        ra1    = 5'd7;
        ra2    = 5'd9;
        #1;
        check("pre_rst_rd1", rd1, 32'h0000_0055);
        check("pre_rst_busy2", 32'(busy2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready), 32'd0);
        check("async_rst_busy2", 32'(busy2), 32'd0);
        check("async_rst_rd1", rd1, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            check($sformatf("reinit_ready_%0d", i), 32'(ready), 32'd0);
            step();
        end
        #1;
        check("reinit_ready", 32'(ready), 32'd1);
        check("reinit_rd1_r7", rd1, 32'd0);
        check("reinit_busy2_r9", 32'(busy2), 32'd0);
        ra1 = 5'd3;
        #1;
        check("reinit_rd1_r3", rd1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
